// File: rtl/enc_parity_arb_if.sv
// ----------------------------------------------------------------------------
// enc_parity_arb_if
//   Bundles the two input channels, the encoded output stream and the
//   per-channel accept counters of enc_parity_arb.
//
//   slave  : the arbiter/encoder side (drives readys, output word, counters)
//   master : the environment side (drives valids, data, out_ready)
//
//   in0_valid/in0_data/in0_ready : channel 0 handshake, 11-bit data
//   in1_valid/in1_data/in1_ready : channel 1 handshake, 11-bit data
//   out_valid/out_ready          : output handshake
//   out_codeword                 : {parity[4:0], data[10:0]}
//   out_src                      : channel that supplied out_codeword
//   cnt0/cnt1                    : accepted-word counts, CNT_W bits each
// ----------------------------------------------------------------------------
interface enc_parity_arb_if #(
   parameter int CNT_W = 8
);
   logic             in0_valid;
   logic [10:0]      in0_data;
   logic             in0_ready;
   logic             in1_valid;
   logic [10:0]      in1_data;
   logic             in1_ready;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_codeword;
   logic             out_src;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_codeword, out_src, cnt0, cnt1
   );

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_codeword, out_src, cnt0, cnt1
   );
endinterface

// File: rtl/enc_parity_arb.sv
// ----------------------------------------------------------------------------
// enc_parity_16bit
//   Parity generator for a 16-bit codeword {parity[4:0], data[10:0]}.
//   data_i   : 11-bit data word
//   parity_o : five parity bits, parity_o[0] = p0 ... parity_o[4] = p4
// ----------------------------------------------------------------------------
module enc_parity_16bit (
   input  logic [10:0] data_i,
   output logic [4:0]  parity_o
);
   assign parity_o[0] = data_i[0] ^ data_i[3] ^ data_i[5] ^ data_i[6] ^
                        data_i[8] ^ data_i[9] ^ data_i[10];
   assign parity_o[1] = ^data_i[6:0];
   assign parity_o[2] = (^data_i[3:0]) ^ (^data_i[9:7]);
   assign parity_o[3] = data_i[0] ^ data_i[1] ^ data_i[4] ^ data_i[5] ^
                        data_i[7] ^ data_i[8] ^ data_i[10];
   assign parity_o[4] = data_i[0] ^ data_i[2] ^ data_i[4] ^ data_i[6] ^
                        data_i[7] ^ data_i[9] ^ data_i[10];
endmodule

// ----------------------------------------------------------------------------
// enc_parity_arb
//   Two-channel round-robin arbiter in front of one shared parity encoder,
//   feeding a single-entry output register. One word per cycle sustained:
//   the output register is refilled in the same cycle it is consumed.
//
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : enc_parity_arb_if.slave (channel handshakes, output, counters)
// ----------------------------------------------------------------------------
module enc_parity_arb #(
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   enc_parity_arb_if.slave     bus
);
   logic             out_valid_q, out_valid_d;
   logic [15:0]      out_codeword_q, out_codeword_d;
   logic             out_src_q, out_src_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic             stage_free;
   logic             gnt0, gnt1;
   logic             acc0, acc1;
   logic [10:0]      sel_data;
   logic [4:0]       sel_parity;

   // The output register can take a new word when empty or being drained.
   assign stage_free = !out_valid_q || bus.out_ready;

   // On contention the channel that did not win last time is served.
   assign gnt0 = stage_free && bus.in0_valid && (!bus.in1_valid || last_grant_q);
   assign gnt1 = stage_free && bus.in1_valid && (!bus.in0_valid || !last_grant_q);

   // Readys are masked by rst_n so nothing looks accepted while in reset.
   assign bus.in0_ready = gnt0 && rst_n;
   assign bus.in1_ready = gnt1 && rst_n;

   assign acc0 = bus.in0_valid && bus.in0_ready;
   assign acc1 = bus.in1_valid && bus.in1_ready;

   // Only the granted channel's data reaches the shared encoder.
   assign sel_data = gnt1 ? bus.in1_data : (gnt0 ? bus.in0_data : 11'h000);

   enc_parity_16bit u_parity (
      .data_i   (sel_data),
      .parity_o (sel_parity)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path leaves
      // one unassigned and no latch is inferred.
      out_valid_d    = out_valid_q;
      out_codeword_d = out_codeword_q;
      out_src_d      = out_src_q;
      last_grant_d   = last_grant_q;
      cnt0_d         = cnt0_q;
      cnt1_d         = cnt1_q;

      if (acc0 || acc1) begin
         out_valid_d    = 1'b1;
         out_codeword_d = {sel_parity, sel_data};
         out_src_d      = acc1;
         last_grant_d   = acc1;
         if (acc0) cnt0_d = cnt0_q + CNT_W'(1);
         if (acc1) cnt1_d = cnt1_q + CNT_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
         // Drained with nothing to replace it: word and source stay visible.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q    <= 1'b0;
         out_codeword_q <= 16'h0000;
         out_src_q      <= 1'b0;
         last_grant_q   <= 1'b1;  // channel 0 wins the first contention
         cnt0_q         <= '0;
         cnt1_q         <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         out_valid_q    <= out_valid_d;
         out_codeword_q <= out_codeword_d;
         out_src_q      <= out_src_d;
         last_grant_q   <= last_grant_d;
         cnt0_q         <= cnt0_d;
         cnt1_q         <= cnt1_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_codeword = out_codeword_q;
   assign bus.out_src      = out_src_q;
   assign bus.cnt0         = cnt0_q;
   assign bus.cnt1         = cnt1_q;
endmodule

// File: tb/tb_enc_parity_arb.sv
// ----------------------------------------------------------------------------
// tb_enc_parity_arb
//   Directed test of enc_parity_arb. Codeword expectations are hand-computed:
//     11'h001 -> 16'hF801   11'h400 -> 16'hCC00   11'h000 -> 16'h0000
//     11'h7FF -> 16'hFFFF   11'h002 -> 16'h7002   11'h080 -> 16'hE080
//   Inputs change 1 ns after a rising edge; combinational readys are looked
//   at 1 ns after that, registered outputs 1 ns after the edge.
// ----------------------------------------------------------------------------
module tb_enc_parity_arb;
   localparam int CNT_W = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   enc_parity_arb_if #(.CNT_W(CNT_W)) bus ();

   enc_parity_arb #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in0_valid = 1'b0;
      bus.in0_data  = 11'h000;
      bus.in1_valid = 1'b0;
      bus.in1_data  = 11'h000;
      bus.out_ready = 1'b1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.in0_valid = 1'b1;
      bus.in1_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.in0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in0_ready: got %b want 0", bus.in0_ready); end
      n_checks++; if (bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in1_ready: got %b want 0", bus.in1_ready); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.out_codeword !== 16'h0000) begin n_fail++; $display("FAIL rst_codeword: got %h want 0000", bus.out_codeword); end
      n_checks++; if (bus.out_src !== 1'b0) begin n_fail++; $display("FAIL rst_out_src: got %b want 0", bus.out_src); end
      n_checks++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: out_valid got %b want 0", bus.out_valid); end
      rst_n = 1'b1;
      idle_inputs();
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle: out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_ch0_single();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 11'h001;
      #1;
      n_checks++; if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL ch0_ready: got %b%b want 10", bus.in0_ready, bus.in1_ready); end
      step();
      bus.in0_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ch0_valid: got %b want 1", bus.out_valid); end
      n_checks++; if (bus.out_codeword !== 16'hF801) begin n_fail++; $display("FAIL ch0_codeword: got %h want F801", bus.out_codeword); end
      n_checks++; if (bus.out_src !== 1'b0) begin n_fail++; $display("FAIL ch0_src: got %b want 0", bus.out_src); end
      n_checks++; if (bus.cnt0 !== 8'd1) begin n_fail++; $display("FAIL ch0_cnt0: got %0d want 1", bus.cnt0); end
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ch0_drain_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.out_codeword !== 16'hF801) begin n_fail++; $display("FAIL ch0_drain_hold: got %h want F801", bus.out_codeword); end
   endtask

   task automatic test_ch1_single();
      bus.in1_valid = 1'b1;
      bus.in1_data  = 11'h400;
      #1;
      n_checks++; if (bus.in1_ready !== 1'b1 || bus.in0_ready !== 1'b0) begin n_fail++; $display("FAIL ch1_ready: got %b%b want 01", bus.in0_ready, bus.in1_ready); end
      step();
      n_checks++; if (bus.out_codeword !== 16'hCC00 || bus.out_src !== 1'b1) begin n_fail++; $display("FAIL ch1_400: got %h src %b want CC00 src 1", bus.out_codeword, bus.out_src); end
      bus.in1_data = 11'h000;
      step();
      n_checks++; if (bus.out_codeword !== 16'h0000 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ch1_000: got %h valid %b want 0000 valid 1", bus.out_codeword, bus.out_valid); end
      bus.in1_data = 11'h7FF;
      step();
      n_checks++; if (bus.out_codeword !== 16'hFFFF) begin n_fail++; $display("FAIL ch1_7ff: got %h want FFFF", bus.out_codeword); end
      n_checks++; if (bus.cnt1 !== 8'd3) begin n_fail++; $display("FAIL ch1_cnt1: got %0d want 3", bus.cnt1); end
      // Withdrawn valids with changing data must leave no trace.
      bus.in1_valid = 1'b0;
      bus.in1_data  = 11'h123;
      bus.in0_data  = 11'h7FF;
      step();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_codeword !== 16'hFFFF) begin n_fail++; $display("FAIL withdrawn_out: got valid %b %h want 0 FFFF", bus.out_valid, bus.out_codeword); end
      n_checks++; if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd3) begin n_fail++; $display("FAIL withdrawn_cnt: got %0d/%0d want 1/3", bus.cnt0, bus.cnt1); end
      idle_inputs();
   endtask

   task automatic test_contention();
      logic exp_src;
      apply_reset();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 11'h001;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 11'h400;
      for (int k = 0; k < 6; k++) begin
         exp_src = k[0];
         #1;
         n_checks++; if (bus.in0_ready !== !exp_src || bus.in1_ready !== exp_src) begin n_fail++; $display("FAIL cont_ready[%0d]: got %b%b want %b%b", k, bus.in0_ready, bus.in1_ready, !exp_src, exp_src); end
         step();
         n_checks++; if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src) begin n_fail++; $display("FAIL cont_src[%0d]: got valid %b src %b want 1 %b", k, bus.out_valid, bus.out_src, exp_src); end
         n_checks++; if (bus.out_codeword !== (exp_src ? 16'hCC00 : 16'hF801)) begin n_fail++; $display("FAIL cont_word[%0d]: got %h want %h", k, bus.out_codeword, exp_src ? 16'hCC00 : 16'hF801); end
      end
      idle_inputs();
      n_checks++; if (bus.cnt0 !== 8'd3 || bus.cnt1 !== 8'd3) begin n_fail++; $display("FAIL cont_cnt: got %0d/%0d want 3/3", bus.cnt0, bus.cnt1); end
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 11'h002;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 11'h080;
      bus.out_ready = 1'b0;
      #1;
      n_checks++; if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_first_ready: got %b%b want 10", bus.in0_ready, bus.in1_ready); end
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_codeword !== 16'h7002) begin n_fail++; $display("FAIL bp_first_word: got %b %h want 1 7002", bus.out_valid, bus.out_codeword); end
      repeat (4) begin
         #1;
         n_checks++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b%b want 00", bus.in0_ready, bus.in1_ready); end
         step();
         n_checks++; if (bus.out_valid !== 1'b1 || bus.out_codeword !== 16'h7002 || bus.out_src !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got %b %h %b want 1 7002 0", bus.out_valid, bus.out_codeword, bus.out_src); end
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b%b want 01", bus.in0_ready, bus.in1_ready); end
      step();
      idle_inputs();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_src !== 1'b1 || bus.out_codeword !== 16'hE080) begin n_fail++; $display("FAIL bp_next_word: got %b %b %h want 1 1 E080", bus.out_valid, bus.out_src, bus.out_codeword); end
      n_checks++; if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d/%0d want 1/1", bus.cnt0, bus.cnt1); end
      step();
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 11'h001;
      repeat (255) step();
      n_checks++; if (bus.cnt0 !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", bus.cnt0); end
      step();
      n_checks++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_stream_valid: got %b want 1", bus.out_valid); end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_transfer();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 11'h002;
      bus.out_ready = 1'b0;
      step();
      bus.in1_valid = 1'b1;
      bus.in1_data  = 11'h080;
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.cnt0 === 8'd0) begin n_fail++; $display("FAIL mid_setup: got valid %b cnt0 %0d want 1 nonzero", bus.out_valid, bus.cnt0); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
      n_checks++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b%b want 00", bus.in0_ready, bus.in1_ready); end
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_grant: got %b%b want 10", bus.in0_ready, bus.in1_ready); end
      step();
      idle_inputs();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_src !== 1'b0 || bus.out_codeword !== 16'h7002) begin n_fail++; $display("FAIL mid_first_word: got %b %b %h want 1 0 7002", bus.out_valid, bus.out_src, bus.out_codeword); end
      n_checks++; if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d/%0d want 1/0", bus.cnt0, bus.cnt1); end
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_ch0_single();
      test_ch1_single();
      test_contention();
      test_backpressure();
      test_wrap();
      test_reset_mid_transfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/enc_parity_arb.md
ENC_PARITY_ARB -- requirements
Module: enc_parity_arb

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel accept counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in0_valid  input  1  channel 0 has a data word.
REQ-005 The block SHALL have port in0_data  input  11  channel 0 data word.
REQ-006 The block SHALL have port in0_ready  output  1  channel 0 word accepted this cycle.
REQ-007 The block SHALL have port in1_valid  input  1  channel 1 has a data word.
REQ-008 The block SHALL have port in1_data  input  11  channel 1 data word.
REQ-009 The block SHALL have port in1_ready  output  1  channel 1 word accepted this cycle.
REQ-010 The block SHALL have port out_valid  output  1  out_codeword holds an encoded word.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the output word.
REQ-012 The block SHALL have port out_codeword  output  16  {parity[4:0], data[10:0]}.
REQ-013 The block SHALL have port out_src  output  1  channel that supplied out_codeword.
REQ-014 The block SHALL have ports cnt0, cnt1  output  CNT_W each  accepted-word count per channel.

Function
REQ-015 The block SHALL share a single instance of the library 16-bit parity generator (enc_parity_16bit) between both channels, driving it with the granted channel's data only.
REQ-016 Parity equations (d = 11-bit data): p0 = d0^d3^d5^d6^d8^d9^d10; p1 = ^d[6:0]; p2 = ^d[3:0] ^ ^d[9:7]; p3 = d0^d1^d4^d5^d7^d8^d10; p4 = d0^d2^d4^d6^d7^d9^d10.
REQ-017 Output stage free (combinational) SHALL be: !out_valid || out_ready.
REQ-018 Grant SHALL be combinational: no grant when the output stage is not free; one valid channel -> that channel; both valid -> channel other than last_grant.
REQ-019 inX_ready SHALL be 1 only in a cycle where channel X is granted; in0_ready and in1_ready SHALL never both be 1.
REQ-020 On accept (inX_valid && inX_ready): next edge loads out_codeword = {parity(inX_data), inX_data}, out_src = X, out_valid = 1, last_grant = X.
REQ-021 When the output is consumed (out_valid && out_ready) and no accept occurs, out_valid SHALL go to 0; out_codeword and out_src SHALL hold.
REQ-022 Consume and accept in the same cycle SHALL replace the word with no bubble; sustained throughput SHALL be one word per cycle.
REQ-023 Latency SHALL be exactly one cycle from accept edge to out_valid.
REQ-024 While out_valid && !out_ready, out_valid, out_codeword and out_src SHALL remain stable and both readys SHALL be 0.
REQ-025 last_grant SHALL change only on an accept; a single requester SHALL NOT move the pointer away from itself except by being granted.
REQ-026 cntX SHALL increment by 1 on each channel-X accept and wrap from 2^CNT_W-1 to 0.
REQ-027 inX_data SHALL be ignored when inX_valid is 0; a withdrawn valid SHALL leave no state change.

Reset
REQ-028 On rst_n low, asynchronously: out_valid = 0, out_codeword = 16'h0000, out_src = 0, cnt0 = cnt1 = 0, last_grant = 1 (channel 0 wins the first contention).
REQ-029 During reset, in0_ready and in1_ready SHALL be 0; reset mid-transfer SHALL discard the held word without emitting it.
REQ-030 The first accept SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-031 Ch0 only, in0_data = 11'h001, out_ready = 1 -> next cycle out_valid = 1, out_codeword = 16'hF801, out_src = 0, cnt0 = 1.
REQ-032 Ch1 only, in1_data = 11'h400 -> out_codeword = 16'hCC00, out_src = 1; in1_data = 11'h000 -> 16'h0000.
REQ-033 Both valid continuously for 6 cycles after reset, out_ready = 1 -> grants 0,1,0,1,0,1; cnt0 = cnt1 = 3; no bubbles.
REQ-034 out_ready = 0 for 4 cycles with both valid -> first word held stable, both readys 0; out_ready = 1 -> the next word, from the other channel, follows immediately.
REQ-035 Ch0 streaming 256 words with CNT_W = 8 -> cnt0 wraps to 0; cnt1 stays 0.
REQ-036 rst_n pulsed low while out_valid = 1 and out_ready = 0 -> out_valid = 0, counters 0, and the first contention after reset goes to channel 0.
